// File: rtl/wbi_arb_pkg.sv
// wbi_arb_pkg: shared types and constants for the four-port command arbiter.
package wbi_arb_pkg;
  localparam int NPORT = 4;
  localparam int TID_HI = 3;
  localparam int TID_LO = 2;
  typedef enum logic {ARB, LOCK} state_t;
endpackage

// File: rtl/wbi_rr_pick.sv
// wbi_rr_pick: round-robin pick of the first request after ptr (ptr+1 .. ptr+4 mod 4).
module wbi_rr_pick
  import wbi_arb_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       idx,
  output logic             vld
);
  always_comb begin
    idx = ptr;
    for (int i = NPORT; i >= 1; i--) if (req[2'(ptr + i)]) idx = 2'(ptr + i);
  end
  assign vld = |req;
endmodule

// File: rtl/wbi_cmd_arb.sv
// wbi_cmd_arb: 4-master round-robin command arbiter with write-burst locking and tid-routed responses.
// Optional LOCK watchdog compiled in with macro WBI_ARB_WDOG_EN.
module wbi_cmd_arb
  import wbi_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int BW       = 4,
  parameter int BL       = 10,
  parameter int WDOG_CYC = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NPORT-1:0]    m_cmd_val_i,
  output logic [NPORT-1:0]    m_cmd_wrdy_o,
  input  logic [NPORT*AW-1:0] m_cmd_adr_i,
  input  logic [NPORT-1:0]    m_cmd_we_i,
  input  logic [NPORT*DW-1:0] m_cmd_dat_i,
  input  logic [NPORT*BW-1:0] m_cmd_sel_i,
  input  logic [NPORT*4-1:0]  m_cmd_tid_i,
  input  logic [NPORT*BL-1:0] m_cmd_bl_i,
  output logic                s_cmd_val_o,
  input  logic                s_cmd_wrdy_i,
  output logic [AW-1:0]       s_cmd_adr_o,
  output logic                s_cmd_we_o,
  output logic [DW-1:0]       s_cmd_dat_o,
  output logic [BW-1:0]       s_cmd_sel_o,
  output logic [3:0]          s_cmd_tid_o,
  output logic [BL-1:0]       s_cmd_bl_o,
  input  logic                s_res_rval_i,
  output logic                s_res_rrdy_o,
  input  logic [DW-1:0]       s_res_dat_i,
  input  logic                s_res_lack_i,
  input  logic                s_res_err_i,
  input  logic [3:0]          s_res_tid_i,
  output logic [NPORT-1:0]    m_res_rval_o,
  input  logic [NPORT-1:0]    m_res_rrdy_i,
  output logic [DW-1:0]       m_res_dat_o,
  output logic                m_res_lack_o,
  output logic                m_res_err_o,
  output logic [3:0]          m_res_tid_o,
  output logic [1:0]          gnt_o,
  output logic                wdog_err_o
);
  state_t        state, state_n;
  logic [1:0]    rr_ptr, rr_n, lock_port, lp_n, last_gnt, pidx, gnt, rp;
  logic [BL-1:0] beat_cnt, cnt_n, bl_g;
  logic          pvld, gv, acc, lock;
  logic [NPORT*4-1:0] unused_tid;

  wbi_rr_pick u_pick (.req(m_cmd_val_i), .ptr(rr_ptr), .idx(pidx), .vld(pvld));

  assign lock = state == LOCK;
  assign gnt  = lock ? lock_port : pvld ? pidx : last_gnt;
  assign gv   = !rst_i && (lock ? m_cmd_val_i[lock_port] : pvld);
  assign acc  = gv && s_cmd_wrdy_i;
  assign bl_g = m_cmd_bl_i[gnt*BL +: BL];

  assign gnt_o        = rst_i ? 2'd0 : gnt;
  assign s_cmd_val_o  = gv;
  assign m_cmd_wrdy_o = gv ? {3'b0, s_cmd_wrdy_i} << gnt : '0;
  assign s_cmd_adr_o  = gv ? m_cmd_adr_i[gnt*AW +: AW] : '0;
  assign s_cmd_dat_o  = gv ? m_cmd_dat_i[gnt*DW +: DW] : '0;
  assign s_cmd_sel_o  = gv ? m_cmd_sel_i[gnt*BW +: BW] : '0;
  assign s_cmd_we_o   = gv & m_cmd_we_i[gnt];
  assign s_cmd_bl_o   = gv ? bl_g : '0;
  assign s_cmd_tid_o  = gv ? {gnt, m_cmd_tid_i[gnt*4 +: 2]} : '0;
  assign unused_tid   = m_cmd_tid_i;

  // Responses carry their destination port in the tid, independent of the command grant.
  assign rp           = s_res_tid_i[TID_HI:TID_LO];
  assign m_res_rval_o = {3'b0, s_res_rval_i} << rp;
  assign s_res_rrdy_o = m_res_rrdy_i[rp];
  assign m_res_dat_o  = s_res_dat_i;
  assign m_res_lack_o = s_res_lack_i;
  assign m_res_err_o  = s_res_err_i;
  assign m_res_tid_o  = s_res_tid_i;

`ifdef WBI_ARB_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYC + 1);
  logic [WCW-1:0] wd_cnt, wd_n;
  logic           werr_n;
`else
  logic unused_wdog;
  assign unused_wdog = WDOG_CYC[0];
  assign wdog_err_o  = 1'b0;
`endif

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    lp_n    = lock_port;
    cnt_n   = beat_cnt;
`ifdef WBI_ARB_WDOG_EN
    wd_n    = '0;
    werr_n  = 1'b0;
`endif
    if (!lock) begin
      if (acc) rr_n = gnt;
      if (acc && m_cmd_we_i[gnt] && bl_g > BL'(1)) begin
        state_n = LOCK;
        lp_n    = gnt;
        cnt_n   = bl_g - BL'(1);
      end
    end else if (acc) begin
      cnt_n = beat_cnt - BL'(beat_cnt != '0);
      if (beat_cnt <= BL'(1)) begin
        state_n = ARB;
        rr_n    = lock_port;
      end
    end
`ifdef WBI_ARB_WDOG_EN
    else if (wd_cnt == WCW'(WDOG_CYC - 1)) begin
      state_n = ARB;
      rr_n    = lock_port;
      werr_n  = 1'b1;
    end else wd_n = wd_cnt + WCW'(1);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state     <= ARB;
      rr_ptr    <= 2'd3;
      lock_port <= '0;
      beat_cnt  <= '0;
      last_gnt  <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      lock_port <= lp_n;
      beat_cnt  <= cnt_n;
      last_gnt  <= gnt;
    end

`ifdef WBI_ARB_WDOG_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wd_cnt     <= '0;
      wdog_err_o <= 1'b0;
    end else begin
      wd_cnt     <= wd_n;
      wdog_err_o <= werr_n;
    end
`endif
endmodule

// File: tb/tb_wbi_cmd_arb.sv
// tb_wbi_cmd_arb: directed stimulus with a per-cycle behavioural model of grant/lock/response rules.
module tb_wbi_cmd_arb;
  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   m_cmd_val_i = '0, m_cmd_we_i = '0, m_cmd_wrdy_o;
  logic [127:0] m_cmd_adr_i = '0, m_cmd_dat_i = '0;
  logic [15:0]  m_cmd_sel_i = '0, m_cmd_tid_i = '0;
  logic [39:0]  m_cmd_bl_i = '0;
  logic         s_cmd_val_o, s_cmd_wrdy_i = 1'b0, s_cmd_we_o;
  logic [31:0]  s_cmd_adr_o, s_cmd_dat_o;
  logic [3:0]   s_cmd_sel_o, s_cmd_tid_o;
  logic [9:0]   s_cmd_bl_o;
  logic         s_res_rval_i = 1'b0, s_res_rrdy_o, s_res_lack_i = 1'b0, s_res_err_i = 1'b0;
  logic [31:0]  s_res_dat_i = 32'h5A5A_0001, m_res_dat_o;
  logic [3:0]   s_res_tid_i = '0, m_res_rval_o, m_res_rrdy_i = '0, m_res_tid_o;
  logic         m_res_lack_o, m_res_err_o, wdog_err_o;
  logic [1:0]   gnt_o;

  int checks = 0, failures = 0;
  int acc_log[$];
  int m_last = 3, m_own = -1, m_left = 0, m_hold = 0, m_stall = 0;
  bit m_werr = 0;

  always #5 clk = ~clk;

  wbi_cmd_arb dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cmd_val_i(m_cmd_val_i), .m_cmd_wrdy_o(m_cmd_wrdy_o), .m_cmd_adr_i(m_cmd_adr_i),
    .m_cmd_we_i(m_cmd_we_i), .m_cmd_dat_i(m_cmd_dat_i), .m_cmd_sel_i(m_cmd_sel_i),
    .m_cmd_tid_i(m_cmd_tid_i), .m_cmd_bl_i(m_cmd_bl_i),
    .s_cmd_val_o(s_cmd_val_o), .s_cmd_wrdy_i(s_cmd_wrdy_i), .s_cmd_adr_o(s_cmd_adr_o),
    .s_cmd_we_o(s_cmd_we_o), .s_cmd_dat_o(s_cmd_dat_o), .s_cmd_sel_o(s_cmd_sel_o),
    .s_cmd_tid_o(s_cmd_tid_o), .s_cmd_bl_o(s_cmd_bl_o),
    .s_res_rval_i(s_res_rval_i), .s_res_rrdy_o(s_res_rrdy_o), .s_res_dat_i(s_res_dat_i),
    .s_res_lack_i(s_res_lack_i), .s_res_err_i(s_res_err_i), .s_res_tid_i(s_res_tid_i),
    .m_res_rval_o(m_res_rval_o), .m_res_rrdy_i(m_res_rrdy_i), .m_res_dat_o(m_res_dat_o),
    .m_res_lack_o(m_res_lack_o), .m_res_err_o(m_res_err_o), .m_res_tid_o(m_res_tid_o),
    .gnt_o(gnt_o), .wdog_err_o(wdog_err_o)
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(string nm, int e[$]);
    chk({nm, "_len"}, acc_log.size(), e.size());
    for (int i = 0; i < e.size() && i < acc_log.size(); i++) chk(nm, acc_log[i], e[i]);
    acc_log.delete();
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_port(int k, bit v, bit we, int bl);
    m_cmd_val_i[k]       = v;
    m_cmd_we_i[k]        = we;
    m_cmd_bl_i[k*10+:10] = 10'(bl);
    m_cmd_adr_i[k*32+:32] = 32'hA000_0000 + 32'(k * 16);
    m_cmd_dat_i[k*32+:32] = 32'hD000_0000 + 32'(k);
    m_cmd_sel_i[k*4+:4]  = 4'(1 << k);
    m_cmd_tid_i[k*4+:4]  = 4'(12 + 3 - k);
  endtask

  task automatic all_off();
    for (int k = 0; k < 4; k++) set_port(k, 0, 0, 1);
  endtask

  // Model: grant = lock owner, else first requester after the last winner; bursts count down beats.
  always @(negedge clk) begin
    logic [1:0] g, rp;
    logic v;
    rp = s_res_tid_i[3:2];
    v = 1'b0;
    g = 2'(m_hold);
    if (rst_i) begin
      m_last = 3; m_own = -1; m_left = 0; m_hold = 0; m_stall = 0; m_werr = 0;
      g = 2'd0;
    end else if (m_own >= 0) begin
      g = 2'(m_own);
      v = m_cmd_val_i[g];
    end else
      for (int k = 1; k <= 4; k++)
        if (!v && m_cmd_val_i[(m_last + k) % 4]) begin
          g = 2'((m_last + k) % 4);
          v = 1'b1;
        end
    chk("s_cmd_val", s_cmd_val_o, v);
    chk("gnt", gnt_o, g);
    chk("m_cmd_wrdy", m_cmd_wrdy_o, (v && s_cmd_wrdy_i) ? 4'(1 << g) : 4'd0);
    chk("s_cmd_adr", s_cmd_adr_o, v ? m_cmd_adr_i[g*32+:32] : 32'd0);
    chk("s_cmd_dat", s_cmd_dat_o, v ? m_cmd_dat_i[g*32+:32] : 32'd0);
    chk("s_cmd_sel", s_cmd_sel_o, v ? m_cmd_sel_i[g*4+:4] : 4'd0);
    chk("s_cmd_we", s_cmd_we_o, v && m_cmd_we_i[g]);
    chk("s_cmd_bl", s_cmd_bl_o, v ? m_cmd_bl_i[g*10+:10] : 10'd0);
    chk("s_cmd_tid", s_cmd_tid_o, v ? {g, m_cmd_tid_i[g*4+:2]} : 4'd0);
    chk("m_res_rval", m_res_rval_o, s_res_rval_i ? 4'(1 << rp) : 4'd0);
    chk("s_res_rrdy", s_res_rrdy_o, m_res_rrdy_i[rp]);
    chk("m_res_bcast", {m_res_dat_o, m_res_tid_o, m_res_lack_o, m_res_err_o},
        {s_res_dat_i, s_res_tid_i, s_res_lack_i, s_res_err_i});
    chk("wdog_err", wdog_err_o, m_werr);
    if (!rst_i && s_cmd_val_o && s_cmd_wrdy_i) acc_log.push_back(int'(gnt_o));
    if (!rst_i) begin
      m_werr = 0;
      if (m_own >= 0) begin
        if (v && s_cmd_wrdy_i) begin
          m_stall = 0;
          m_left--;
          if (m_left == 0) begin m_own = -1; m_last = g; end
        end
`ifdef WBI_ARB_WDOG_EN
        else begin
          m_stall++;
          if (m_stall == 16) begin m_own = -1; m_last = g; m_werr = 1; m_stall = 0; end
        end
`endif
      end else if (v && s_cmd_wrdy_i) begin
        m_last = g;
        if (m_cmd_we_i[g] && m_cmd_bl_i[g*10+:10] > 10'd1) begin
          m_own = g;
          m_left = int'(m_cmd_bl_i[g*10+:10]) - 1;
          m_stall = 0;
        end
      end
      m_hold = g;
    end
  end

  initial begin
    int exp_q[$];
    int n;
    for (int k = 0; k < 4; k++) set_port(k, 1, 0, 1);
    s_cmd_wrdy_i = 1'b1;
    tick(2);
    chk("rst_val", s_cmd_val_o, 1'b0);
    chk("rst_wrdy", m_cmd_wrdy_o, 4'd0);
    chk("rst_gnt", gnt_o, 2'd0);
    chk("rst_adr", s_cmd_adr_o, 32'd0);
    chk("rst_werr", wdog_err_o, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("first_gnt", gnt_o, 2'd0);
    chk("first_tid", s_cmd_tid_o, 4'b0011);
    chk("first_adr", s_cmd_adr_o, 32'hA000_0000);
    acc_log.delete();
    tick(5);
    exp_q = '{0, 1, 2, 3, 0};
    chk_log("rr_order", exp_q);

    all_off();
    set_port(1, 1, 1, 4);
    set_port(2, 1, 0, 1);
    tick(5);
    exp_q = '{1, 1, 1, 1, 2};
    chk_log("burst4", exp_q);
    all_off();
    tick(2);
    chk("idle_hold_gnt", gnt_o, 2'd2);

    set_port(1, 1, 1, 4);
    tick(1);
    set_port(0, 1, 0, 1);
    tick(1);
    s_cmd_wrdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_gnt", gnt_o, 2'd1);
      chk("stall_wrdy", m_cmd_wrdy_o, 4'd0);
      tick(1);
    end
    s_cmd_wrdy_i = 1'b1;
    tick(3);
    all_off();
    exp_q = '{1, 1, 1, 1, 0};
    chk_log("stall_burst", exp_q);

    set_port(0, 1, 0, 1);
    s_res_rval_i = 1'b1;
    s_res_tid_i  = 4'b1001;
    m_res_rrdy_i = 4'b0100;
    #1;
    chk("res_rval", m_res_rval_o, 4'b0100);
    chk("res_rrdy", s_res_rrdy_o, 1'b1);
    chk("res_cmd_wrdy", m_cmd_wrdy_o, 4'b0001);
    s_res_tid_i = 4'b1101;
    #1;
    chk("res_rval3", m_res_rval_o, 4'b1000);
    chk("res_rrdy3", s_res_rrdy_o, 1'b0);
    tick(1);
    all_off();
    s_res_rval_i = 1'b0;
    m_res_rrdy_i = 4'd0;
    acc_log.delete();

    set_port(1, 1, 1, 4);
    tick(2);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_val", s_cmd_val_o, 1'b0);
    chk("midrst_gnt", gnt_o, 2'd0);
    for (int k = 0; k < 4; k++) set_port(k, 1, 0, 1);
    tick(1);
    rst_i = 1'b0;
    acc_log.delete();
    #1;
    chk("postrst_gnt", gnt_o, 2'd0);
    tick(1);
    exp_q = '{0};
    chk_log("postrst", exp_q);
    all_off();
    tick(1);

    set_port(1, 1, 1, 1);
    set_port(2, 1, 1, 0);
    set_port(3, 1, 0, 1);
    tick(3);
    exp_q = '{1, 2, 3};
    chk_log("bl01_nolock", exp_q);
    all_off();
    set_port(1, 1, 1, 2);
    set_port(2, 1, 0, 1);
    tick(3);
    exp_q = '{1, 1, 2};
    chk_log("bl2_lock", exp_q);
    all_off();
    tick(1);

`ifdef WBI_ARB_WDOG_EN
    set_port(2, 1, 1, 4);
    tick(1);
    s_cmd_wrdy_i = 1'b0;
    set_port(3, 1, 0, 1);
    n = 0;
    while (n < 40 && !wdog_err_o) begin
      tick(1);
      n++;
    end
    chk("wdog_cycles", n, 16);
    chk("wdog_gnt", gnt_o, 2'd3);
    tick(1);
    chk("wdog_pulse_end", wdog_err_o, 1'b0);
    all_off();
    s_cmd_wrdy_i = 1'b1;
    tick(2);
`else
    n = 0;
    set_port(2, 1, 1, 4);
    tick(1);
    s_cmd_wrdy_i = 1'b0;
    while (n < 20) begin
      tick(1);
      n++;
      chk("nowdog_gnt", gnt_o, 2'd2);
    end
    s_cmd_wrdy_i = 1'b1;
    tick(3);
    all_off();
    tick(2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
